// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- single-cycle registered ALU.
//
// Operations are selected by a 3-bit control (ALUOp): AND, OR, ADD, XOR, NOR,
// SLTU, SUB, SLT. Operands are sampled on a rising clk edge when in_valid is
// high. The result and zero flag are registered, so latency is exactly one
// cycle. Both hold while in_valid is low.
//
// Optional feature: define ALU_OVERFLOW_EN to add a registered signed-overflow
// flag. The flag is set for ADD and SUB and is 0 for every other op.
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high reset
//   A, B      in   WIDTH  operands (two's complement for signed ops)
//   control   in   3      operation select
//   in_valid  in   1      sample A/B/control on this edge
//   result    out  WIDTH  registered operation result
//   zero      out  1      registered, high when result == 0
//   out_valid out  1      in_valid delayed by one cycle
//   overflow  out  1      (ALU_OVERFLOW_EN only) signed overflow on ADD/SUB
// ---------------------------------------------------------------------------

// Per-bit slice of the bitwise operations. Arithmetic and compare ops are
// handled at word level in the top module, so this slice returns 0 for them.
module alu_lane (
  input  logic       a,
  input  logic       b,
  input  logic [2:0] op,
  output logic       y
);
  always_comb begin
    y = 1'b0;
    case (op)
      3'b000:  y = a & b;
      3'b001:  y = a | b;
      3'b011:  y = a ^ b;
      3'b100:  y = ~(a | b);
      default: y = 1'b0;
    endcase
  end
endmodule

module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
`ifdef ALU_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             out_valid
);

  localparam int STAGES = 1;
  localparam int MSB    = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_XOR  = 3'b011,
    OP_NOR  = 3'b100,
    OP_SLTU = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_e              op;
  } req_t;

  req_t req;
  assign req = '{a: A, b: B, op: op_e'(control)};

  // Bitwise ops, one slice per bit.
  logic [WIDTH-1:0] logic_y;
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    alu_lane u_lane (
      .a  (req.a[i]),
      .b  (req.b[i]),
      .op (control),
      .y  (logic_y[i])
    );
  end

  // One shared subtractor, widened by a bit so that its top bit is the
  // unsigned borrow. That borrow gives SLTU directly.
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   diff_full;
  logic [WIDTH-1:0] diff;
  logic             ltu;
  logic             lts;

  assign sum       = req.a + req.b;
  assign diff_full = {1'b0, req.a} - {1'b0, req.b};
  assign diff      = diff_full[MSB:0];
  assign ltu       = diff_full[WIDTH];
  // If the sign bits differ, the negative operand is the smaller one. If they
  // match, A-B cannot overflow, so the sign of the difference is the answer.
  assign lts       = (req.a[MSB] ^ req.b[MSB]) ? req.a[MSB] : diff[MSB];

  logic [WIDTH-1:0] op_val;
  always_comb begin
    op_val = logic_y;
    case (req.op)
      OP_ADD:  op_val = sum;
      OP_SUB:  op_val = diff;
      OP_SLTU: op_val = {{(WIDTH-1){1'b0}}, ltu};
      OP_SLT:  op_val = {{(WIDTH-1){1'b0}}, lts};
      default: op_val = logic_y;
    endcase
  end

  // Valid pipeline. Bit 0 is the live input and bit STAGES is the output.
  logic [STAGES:0] vld_pipe;
  logic            vld_q;
  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_q <= 1'b0;
    else       vld_q <= vld_pipe[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      zero   <= 1'b1;
    end else if (in_valid) begin
      result <= op_val;
      zero   <= (op_val == '0);
    end
  end

`ifdef ALU_OVERFLOW_EN
  // ADD overflows when the operands share a sign that the sum does not.
  // SUB overflows when the operands differ in sign and the difference takes
  // B's sign.
  logic ovf_val;
  always_comb begin
    ovf_val = 1'b0;
    case (req.op)
      OP_ADD:  ovf_val = (req.a[MSB] == req.b[MSB]) && (sum[MSB]  != req.a[MSB]);
      OP_SUB:  ovf_val = (req.a[MSB] != req.b[MSB]) && (diff[MSB] != req.a[MSB]);
      default: ovf_val = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         overflow <= 1'b0;
    else if (in_valid) overflow <= ovf_val;
  end
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu (WIDTH = 32).
module tb_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [2:0]   control = 3'b000;
  logic         in_valid = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         out_valid;
`ifdef ALU_OVERFLOW_EN
  logic         overflow;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .control   (control),
    .in_valid  (in_valid),
    .result    (result),
    .zero      (zero),
`ifdef ALU_OVERFLOW_EN
    .overflow  (overflow),
`endif
    .out_valid (out_valid)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one input set, then sample 1 time unit after the next rising edge.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] c, input logic v);
    A = a; B = b; control = c; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] r, input logic z,
                           input logic ov);
    check({tag, ".result"}, result, r);
    check({tag, ".zero"}, {31'b0, zero}, {31'b0, z});
    check({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, ov});
  endtask

  logic [W-1:0] exp27 [8];

  initial begin
    exp27 = '{32'd2, 32'd15, 32'd17, 32'd13, 32'hFFFF_FFF0, 32'd0, 32'd3, 32'd0};

    // Async reset between clock edges, with an in_valid present that must be dropped.
    A = 32'd3; B = 32'd4; control = 3'b010; in_valid = 1'b1;
    #1 reset = 1'b1;
    #1 check_out("reset_async", 32'd0, 1'b1, 1'b0);
`ifdef ALU_OVERFLOW_EN
    check("reset_async.overflow", {31'b0, overflow}, 32'd0);
`endif
    @(posedge clk); #1;
    check_out("reset_held", 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;

    // A=10, B=7, every op back to back.
    for (int i = 0; i < 8; i++) begin
      step(32'd10, 32'd7, i[2:0], 1'b1);
      check_out($sformatf("ops10_7[%0d]", i), exp27[i], (i == 5 || i == 7), 1'b1);
    end

    // Bitwise ops on mixed patterns. Every bit position is exercised.
    step(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 1'b1);
    check_out("and_pat", 32'hF000_F000, 1'b0, 1'b1);
    step(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, 1'b1);
    check_out("or_pat", 32'hFFF0_FFF0, 1'b0, 1'b1);
    step(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011, 1'b1);
    check_out("xor_pat", 32'h0FF0_0FF0, 1'b0, 1'b1);
    step(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 1'b1);
    check_out("nor_pat", 32'h000F_000F, 1'b0, 1'b1);

    // A < B cases and a signed-versus-unsigned disagreement.
    step(32'd7, 32'd10, 3'b110, 1'b1);
    check_out("sub7_10", 32'hFFFF_FFFD, 1'b0, 1'b1);
    step(32'd7, 32'd10, 3'b111, 1'b1);
    check_out("slt7_10", 32'd1, 1'b0, 1'b1);
    step(32'd7, 32'd10, 3'b101, 1'b1);
    check_out("sltu7_10", 32'd1, 1'b0, 1'b1);
    step(32'hFFFF_FFFF, 32'd1, 3'b111, 1'b1);
    check_out("slt_m1_1", 32'd1, 1'b0, 1'b1);
    step(32'hFFFF_FFFF, 32'd1, 3'b101, 1'b1);
    check_out("sltu_m1_1", 32'd0, 1'b1, 1'b1);

    // Overflow boundaries.
    step(32'h7FFF_FFFF, 32'd1, 3'b010, 1'b1);
    check_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
`ifdef ALU_OVERFLOW_EN
    check("add_ovf.overflow", {31'b0, overflow}, 32'd1);
`endif
    step(32'h7FFF_FFFF, 32'd1, 3'b000, 1'b1);
    check_out("and_after_ovf", 32'd1, 1'b0, 1'b1);
`ifdef ALU_OVERFLOW_EN
    check("and_after_ovf.overflow", {31'b0, overflow}, 32'd0);
`endif
    step(32'h8000_0000, 32'd1, 3'b110, 1'b1);
    check_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1);
`ifdef ALU_OVERFLOW_EN
    check("sub_ovf.overflow", {31'b0, overflow}, 32'd1);
`endif
    step(32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 1'b1);
    check_out("slt_min_max", 32'd1, 1'b0, 1'b1);
    step(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 1'b1);
    check_out("sltu_min_max", 32'd0, 1'b1, 1'b1);

    // A nonzero result must be held while in_valid is low.
    step(32'd3, 32'd4, 3'b010, 1'b1);
    check_out("add3_4", 32'd7, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(32'd100 + i, 32'd100, 3'b110, 1'b0);
      check_out($sformatf("hold7[%0d]", i), 32'd7, 1'b0, 1'b0);
    end

    // A zero result must also be held while in_valid is low and A/B change.
    step(32'd5, 32'd5, 3'b110, 1'b1);
    check_out("sub5_5", 32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(32'd9 + i, 32'd2 * i, 3'b010, 1'b0);
      check_out($sformatf("hold0[%0d]", i), 32'd0, 1'b1, 1'b0);
    end

    // Reset raised mid-stream, between edges.
    step(32'd10, 32'd7, 3'b010, 1'b1);
    check_out("pre_reset", 32'd17, 1'b0, 1'b1);
    A = 32'd9; B = 32'd9;
    #3 reset = 1'b1;
    #1 check_out("mid_reset", 32'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_out("mid_reset_edge", 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(32'd3, 32'd4, 3'b010, 1'b1);
    check_out("post_reset_add", 32'd7, 1'b0, 1'b1);
    step(32'd3, 32'd4, 3'b010, 1'b0);
    check_out("post_reset_idle", 32'd7, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
